// File: rtl/fusion_seq_ctrl.sv
// Purpose  : dot-product sequencer for one fusion multiplier tile; streams operand
//            pairs into the tile, accumulates returned psums, emits one result per job.
// Latency  : len + FU_LAT + 1 cycles from accepted start to res_valid (no stalls).
// Backpres.: op_ready depends only on state/count; res_valid/res_data hold until res_ready.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start, len, bias, s_*_cfg      job request, sampled in IDLE only
//   busy                           high from accepted start until result handshake
//   op_valid/op_ready, op_in/op_weight   operand pair stream in
//   fu_in, fu_weight, fu_psum_in, fu_s_in, fu_s_weight   registered drive to the tile
//   fu_psum_fwd                    tile result, FU_LAT cycles after fu_* update
//   res_valid/res_ready, res_data  job result out
module fusion_seq_ctrl #(
    parameter int LEN_W  = 10,
    parameter int FU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [18:0]      bias,
    input  logic             s_in_cfg,
    input  logic             s_weight_cfg,
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_in,
    input  logic [7:0]       op_weight,
    output logic [7:0]       fu_in,
    output logic [7:0]       fu_weight,
    output logic [18:0]      fu_psum_in,
    output logic             fu_s_in,
    output logic             fu_s_weight,
    input  logic [18:0]      fu_psum_fwd,
    output logic             res_valid,
    output logic [18:0]      res_data,
    input  logic             res_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    // One bit per tile pipeline slot: 1 marks a real beat whose psum must be summed.
    logic [FU_LAT-1:0] r_tags;
    logic [18:0]       r_acc;

    logic              w_accept;
    logic              w_tag_out;
    logic              w_last;

    // Ready never looks at op_valid, so the producer may wait on it without a loop.
    assign op_ready  = (r_state == ISSUE) && (r_issued < r_len);
    assign w_accept  = op_valid & op_ready;
    assign w_tag_out = r_tags[FU_LAT-1];
    assign w_last    = w_accept && (r_issued == (r_len - LEN_ONE));

    // Tile is used as a pure multiplier; accumulation happens here.
    assign fu_psum_in = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_issued    <= '0;
            r_tags      <= '0;
            r_acc       <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            fu_in       <= '0;
            fu_weight   <= '0;
            fu_s_in     <= 1'b0;
            fu_s_weight <= 1'b0;
        end else begin
            // Idle slots present zero operands so the tile output carries no stale product.
            fu_in     <= w_accept ? op_in     : 8'd0;
            fu_weight <= w_accept ? op_weight : 8'd0;
            r_tags    <= (r_tags << 1) | FU_LAT'(w_accept);

            if (w_tag_out) begin
                r_acc <= r_acc + fu_psum_fwd;
            end
            if (w_accept) begin
                r_issued <= r_issued + LEN_ONE;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len       <= len;
                        fu_s_in     <= s_in_cfg;
                        fu_s_weight <= s_weight_cfg;
                        r_acc       <= bias;
                        r_issued    <= '0;
                        busy        <= 1'b1;
                        if (len != '0) begin
                            r_state <= ISSUE;
                        end else begin
                            r_state   <= DONE;
                            res_data  <= bias;
                            res_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (w_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Empty register also means no tag exits this edge, so r_acc is final.
                    if (r_tags == '0) begin
                        r_state   <= DONE;
                        res_data  <= r_acc;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
